// File: rtl/shift_rows_collect_pkg.sv
// Shared constants, state encoding and the ShiftRows byte mapping for the
// byte-serial AES ShiftRows collector.
package shift_rows_collect_pkg;

  localparam int STATE_BYTES = 16;
  localparam int BYTE_W      = 8;
  localparam int BLOCK_W     = STATE_BYTES * BYTE_W;

  // Packed block: element STATE_BYTES-1 holds state byte 0, so the flat
  // vector has byte 0 in its top bits.
  typedef logic [STATE_BYTES-1:0][BYTE_W-1:0] block_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  // Output byte n (row n mod 4, column n div 4) takes the stored byte of the
  // same row, rotated left by the row number.
  function automatic int sr_src_index(input int n);
    return (n % 4) + 4 * (((n / 4) + (n % 4)) % 4);
  endfunction

endpackage

// File: rtl/shift_rows_collect_shift_rows.sv
// Pure ShiftRows byte permutation on a 128-bit block (byte 0 in the top bits).
module shift_rows
  import shift_rows_collect_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_in,
  output logic [BLOCK_W-1:0] block_out
);

  block_t src_blk;
  block_t dst_blk;

  assign src_blk = block_in;

  for (genvar n = 0; n < STATE_BYTES; n++) begin : g_byte
    assign dst_blk[STATE_BYTES-1-n] = src_blk[STATE_BYTES-1-sr_src_index(n)];
  end

  assign block_out = dst_blk;

endmodule

// File: rtl/shift_rows_collect.sv
// Collects 16 SubBytes result bytes, applies ShiftRows, and presents the
// block with a valid/ready handshake.
//
// state      | meaning
// ST_COLLECT | accepting bytes, count_q bytes already held (0..15)
// ST_HOLD    | complete ShiftRows'd block presented on output_data
module shift_rows_collect
  import shift_rows_collect_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               input_valid,
  output logic               input_ready,
  input  logic [BYTE_W-1:0]  input_data,
  input  logic               flush,
  output logic               output_valid,
  input  logic               output_ready,
  output logic [BLOCK_W-1:0] output_data
);

  state_e             state_q;
  state_e             state_d;
  logic [3:0]         count_q;
  block_t             buf_q;
  block_t             out_q;
  logic               run_q;
  logic               in_fire;
  logic               out_fire;
  logic               last_byte;
  logic [BLOCK_W-1:0] full_block;
  logic [BLOCK_W-1:0] shifted;

  assign in_fire   = input_valid && input_ready;
  assign out_fire  = output_valid && output_ready;
  assign last_byte = (state_q == ST_COLLECT) && (count_q == 4'(STATE_BYTES-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (in_fire && last_byte) state_d = ST_HOLD;
      ST_HOLD:    if (out_fire)             state_d = ST_COLLECT;
      default:                              state_d = ST_COLLECT;
    endcase
  end

  // run_q keeps the input closed until the first clock after reset release.
  always_comb begin
    input_ready  = 1'b0;
    output_valid = 1'b0;
    case (state_q)
      ST_COLLECT: input_ready = run_q && !flush;
      ST_HOLD: begin
        input_ready  = output_ready;
        output_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // The last byte bypasses the buffer so the shifted block registers on the
  // same edge that accepts it.
  assign full_block = {buf_q[STATE_BYTES-1:1], input_data};

  shift_rows u_shift_rows (
    .block_in  (full_block),
    .block_out (shifted)
  );

  // In HOLD count_q is 0, so a byte taken during block transfer lands as byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      count_q <= '0;
      buf_q   <= '0;
      out_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (in_fire) begin
        buf_q[4'(STATE_BYTES-1) - count_q] <= input_data;
        count_q <= last_byte ? 4'd0 : count_q + 4'd1;
      end else if (flush && (state_q == ST_COLLECT)) begin
        count_q <= '0;
      end
      if (in_fire && last_byte) begin
        out_q <= shifted;
      end
    end
  end

  assign output_data = out_q;

endmodule

// File: tb/tb_shift_rows_collect.sv
// Self-checking bench for shift_rows_collect: directed scenarios plus a long
// randomized run against a ShiftRows reference model.
module tb_shift_rows_collect;

  localparam logic [127:0] KAT = 128'h00050A0F04090E03080D02070C01060B;

  logic         clk;
  logic         rst_n;
  logic         input_valid;
  logic         input_ready;
  logic [7:0]   input_data;
  logic         flush;
  logic         output_valid;
  logic         output_ready;
  logic [127:0] output_data;

  logic         obs_ready;
  logic         obs_valid;
  logic [127:0] obs_data;

  int n_pass;
  int n_total;

  shift_rows_collect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .flush        (flush),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: output byte n = input byte (n mod 4) + 4*(((n div 4) + (n mod 4)) mod 4)
  function automatic logic [127:0] sr_model(input logic [7:0] b [16]);
    logic [127:0] res;
    int r;
    int c;
    res = '0;
    for (int n = 0; n < 16; n++) begin
      r = n % 4;
      c = n / 4;
      res = {res[119:0], b[r + 4 * ((c + r) % 4)]};
    end
    return res;
  endfunction

  // Drive one cycle's inputs at the falling edge and capture outputs just after.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    input_valid  = v;
    input_data   = d;
    output_ready = ordy;
    flush        = fl;
    #1;
    obs_ready = input_ready;
    obs_valid = output_valid;
    obs_data  = output_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    input_valid = 1'b1;
    input_data = 8'h5A;
    output_ready = 1'b1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (output_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", output_valid);
    else n_pass++;
    n_total++;
    if (output_data !== 128'h0) $display("FAIL reset_data: got %h expected 0", output_data);
    else n_pass++;
    n_total++;
    if (input_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", input_ready);
    else n_pass++;
    @(negedge clk);
    input_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_total++;
    if (obs_ready !== 1'b1) $display("FAIL post_reset_ready: got %b expected 1", obs_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 8'(k), 1'b1, 1'b0);
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL basic_collect: got %0d bad cycles expected 0", bad);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", obs_valid);
    else n_pass++;
    n_total++;
    if (obs_data !== KAT) $display("FAIL basic_data: got %h expected %h", obs_data, KAT);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b0) $display("FAIL basic_held_once: got %b expected 0", obs_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      if (obs_valid !== 1'b1 || obs_data !== KAT || obs_ready !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", bad);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b1 || obs_data !== KAT)
      $display("FAIL bp_transfer: got valid %b data %h expected 1 %h", obs_valid, obs_data, KAT);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", obs_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    int bad;
    for (int k = 0; k < 16; k++) begin
      a[k] = 8'($urandom);
      b[k] = 8'($urandom);
    end
    exp_a = sr_model(a);
    exp_b = sr_model(b);
    for (int k = 0; k < 16; k++) step(1'b1, a[k], 1'b1, 1'b0);
    step(1'b1, b[0], 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b1 || obs_ready !== 1'b1 || obs_data !== exp_a)
      $display("FAIL b2b_first: got v%b r%b %h expected v1 r1 %h", obs_valid, obs_ready, obs_data, exp_a);
    else n_pass++;
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      step(1'b1, b[k], 1'b1, 1'b0);
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL b2b_collect: got %0d bad cycles expected 0", bad);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b1 || obs_data !== exp_b)
      $display("FAIL b2b_second: got v%b %h expected v1 %h", obs_valid, obs_data, exp_b);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 7; k++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b1);
    n_total++;
    if (obs_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", obs_ready);
    else n_pass++;
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_total++;
    if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_data !== KAT)
      $display("FAIL flush_hold: got v%b r%b %h expected v1 r0 %h", obs_valid, obs_ready, obs_data, KAT);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    n_total++;
    if (obs_valid !== 1'b1 || obs_ready !== 1'b1 || obs_data !== KAT)
      $display("FAIL flush_in_hold: got v%b r%b %h expected v1 r1 %h", obs_valid, obs_ready, obs_data, KAT);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b0) $display("FAIL flush_done: got %b expected 0", obs_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) step(1'b1, 8'hF0 + 8'(k), 1'b1, 1'b0);
    @(negedge clk);
    input_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (output_data !== 128'h0 || output_valid !== 1'b0 || input_ready !== 1'b0)
      $display("FAIL mid_reset: got v%b r%b %h expected v0 r0 0", output_valid, input_ready, output_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b1 || obs_data !== KAT)
      $display("FAIL mid_reset_block: got v%b %h expected v1 %h", obs_valid, obs_data, KAT);
    else n_pass++;
    for (int k = 0; k < 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_total++;
    if (obs_valid !== 1'b0 || obs_data !== 128'h0)
      $display("FAIL hold_reset_discard: got v%b %h expected v0 0", obs_valid, obs_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0]   bytes [16];
    logic [127:0] exp_blk;
    logic         pending;
    logic         exp_ready;
    logic         v;
    logic         ordy;
    logic [7:0]   d;
    int           fill;
    int           blocks_out;
    int           cycles;
    pending = 1'b0;
    exp_blk = '0;
    fill = 0;
    blocks_out = 0;
    cycles = 0;
    while (blocks_out < 1000 && cycles < 60000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = 8'($urandom);
      step(v, d, ordy, 1'b0);
      cycles++;
      exp_ready = pending ? ordy : 1'b1;
      n_total++;
      if (obs_valid !== pending) $display("FAIL rand_valid: got %b expected %b cycle %0d", obs_valid, pending, cycles);
      else n_pass++;
      n_total++;
      if (obs_ready !== exp_ready) $display("FAIL rand_ready: got %b expected %b cycle %0d", obs_ready, exp_ready, cycles);
      else n_pass++;
      if (pending) begin
        n_total++;
        if (obs_data !== exp_blk) $display("FAIL rand_data: got %h expected %h block %0d", obs_data, exp_blk, blocks_out);
        else n_pass++;
      end
      if (pending && ordy) begin
        pending = 1'b0;
        blocks_out++;
      end
      if (v && exp_ready) begin
        bytes[fill] = d;
        fill++;
        if (fill == 16) begin
          exp_blk = sr_model(bytes);
          pending = 1'b1;
          fill = 0;
        end
      end
    end
    n_total++;
    if (blocks_out != 1000) $display("FAIL rand_budget: got %0d blocks expected 1000", blocks_out);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_rows_collect.md
SHIFT_ROWS_COLLECT -- requirements
Module: shift_rows_collect

Interface
REQ-001 Parameters SHALL be none; byte width 8 and block size 16 are fixed constants.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 input_valid  input  1  upstream s_box_forward output_data byte is valid.
REQ-005 input_ready  output  1  block can accept a byte this cycle.
REQ-006 input_data  input  8  substituted byte (SubBytes result), state order byte 0..15.
REQ-007 flush  input  1  synchronous discard of a partially collected block.
REQ-008 output_valid  output  1  output_data holds a complete ShiftRows'd block.
REQ-009 output_ready  input  1  downstream accepts the block this cycle.
REQ-010 output_data  output  128  ShiftRows result; state byte 0 in bits [127:120], byte 15 in [7:0].

Function
REQ-011 Byte transfer SHALL occur on a rising edge where input_valid && input_ready; block transfer where output_valid && output_ready.
REQ-012 State machine SHALL have two states: COLLECT (count 0..15 bytes held) and HOLD (complete block presented).
REQ-013 In COLLECT, input_ready SHALL be 1 unless flush is 1; output_valid SHALL be 0.
REQ-014 Each accepted byte k (k = current count) SHALL be stored as state byte k at row k mod 4, column k div 4; count increments by 1.
REQ-015 Acceptance of byte 15 SHALL move the FSM to HOLD; output_valid SHALL be 1 on the following cycle (latency 1 cycle from last byte to valid).
REQ-016 output_data SHALL be registered: output byte n (row r = n mod 4, col c = n div 4) equals stored byte r + 4*((c + r) mod 4).
REQ-017 In HOLD, output_valid SHALL be 1 and output_data stable until block transfer, regardless of output_ready.
REQ-018 In HOLD, input_ready SHALL equal output_ready; a byte accepted in the same cycle as block transfer becomes byte 0 of the next block (count = 1, state COLLECT).
REQ-019 Block transfer without simultaneous byte acceptance SHALL return to COLLECT with count = 0.
REQ-020 flush = 1 in COLLECT SHALL force count to 0 next cycle and drop any byte presented that cycle (input_ready is 0).
REQ-021 flush = 1 in HOLD SHALL be ignored; block and handshake unaffected.
REQ-022 input_valid = 0 gaps of any length SHALL not disturb count or stored bytes.
REQ-023 input_data and output_ready values while their companion valid/ready are low SHALL have no effect.

Reset
REQ-024 reset low SHALL immediately force state COLLECT, count 0, output_valid 0, output_data 128'h0.
REQ-025 input_ready SHALL be 0 while reset is low and 1 from the first cycle after release.
REQ-026 Reset asserted mid-block or in HOLD SHALL discard all stored bytes; no block is emitted.

Structure
REQ-027 Shared package SHALL hold STATE_BYTES = 16, BYTE_W = 8, the FSM state enum, and the ShiftRows source-index function.
REQ-028 One combinational sub-module shift_rows (128-bit in, 128-bit out, pure permutation) SHALL be used; counter, byte buffer and FSM stay in shift_rows_collect.

Verification
REQ-029 Bytes 0x00..0x0F back-to-back, output_ready = 1 -> output_data = 00050A0F04090E03080D02070C01060B, output_valid 1 cycle after byte 15, held 1 cycle.
REQ-030 Same block, output_ready = 0 for 5 cycles -> output_valid and output_data stable 5 cycles, input_ready 0 throughout, transfer on 6th.
REQ-031 Two blocks streamed with output_ready = 1 and first byte of block 2 coincident with block-1 transfer -> both blocks correct, no byte lost.
REQ-032 7 bytes, flush pulse, then 0x00..0x0F -> single block equal to REQ-029 value; flush during HOLD -> block still delivered.
REQ-033 reset low after 10 bytes, release, then 0x00..0x0F -> output_data reads 0 during reset, then REQ-029 value.
REQ-034 Random input_valid/output_ready gaps over 1000 blocks -> output matches reference ShiftRows model, zero drops or duplicates.
